// File: rtl/dspuva_io_pkg.sv
// Shared constants for the DSPuva16 I/O-port responder: register offsets,
// STATUS/CTRL bit positions and the stored control-register layout.
package dspuva_io_pkg;

    localparam logic [1:0] OFF_DATA    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_CTRL    = 2'd2;
    localparam logic [1:0] OFF_SCRATCH = 2'd3;

    localparam int ST_TXCNT_LSB = 0;
    localparam int ST_RXCNT_LSB = 4;
    localparam int ST_TX_FULL   = 8;
    localparam int ST_RX_EMPTY  = 9;
    localparam int ST_TXOVF     = 10;
    localparam int ST_RXUNF     = 11;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_LOOP     = 2;
    localparam int CTRL_TX_FLUSH = 3;
    localparam int CTRL_RX_FLUSH = 4;

    typedef struct packed {
        logic loop;
        logic rx_en;
        logic tx_en;
    } ctrl_t;

endpackage

// File: rtl/dspuva_io_port_fifo.sv
// Synchronous FIFO used for both the TX and RX queues of the I/O port.
// Push to a full FIFO is accepted only when a pop happens in the same cycle.
module dspuva_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rptr];

    // When full, a simultaneous pop frees the slot the push writes into.
    assign w_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_push = i_push & (~o_full | w_pop) & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_reset) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/dspuva_io_port.sv
// DSPuva16 IOR/IOW responder: DATA/STATUS/CTRL/SCRATCH window at BASE with
// TX and RX FIFOs bridging the port bus to valid/ready streams.
module dspuva_io_port
    import dspuva_io_pkg::*;
#(
    parameter logic [7:0] BASE  = 8'h10,
    parameter int         DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_port,
    input  logic        i_ior,
    input  logic        i_iow,
    input  logic [23:0] i_dout24,
    output logic [23:0] o_din,
    output logic        o_sel,
    output logic [23:0] o_txd,
    output logic        o_txv,
    input  logic        i_txr,
    input  logic [23:0] i_rxd,
    input  logic        i_rxv,
    output logic        o_rxr
);

    localparam int CW = $clog2(DEPTH) + 1;

    ctrl_t       r_ctrl;
    logic        r_txovf;
    logic        r_rxunf;
    logic [23:0] r_scratch;
    logic [23:0] r_din;

    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic        w_ctrl_wr;
    logic        w_st_wr;
    logic        w_data_rd;
    logic        w_tx_flush;
    logic        w_rx_flush;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic [CW-1:0] w_tx_cnt;
    logic [23:0] w_tx_head;
    logic        w_loop_push;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic [23:0] w_rx_wdata;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic [CW-1:0] w_rx_cnt;
    logic [23:0] w_rx_head;
    logic        w_ovf_set;
    logic        w_unf_set;
    logic [23:0] w_status;
    logic [23:0] w_rdata;

    assign o_sel     = (i_port[7:2] == BASE[7:2]);
    assign w_off     = i_port[1:0];
    assign w_wr      = i_iow & o_sel;
    assign w_rd      = i_ior & o_sel;
    assign w_ctrl_wr = w_wr & (w_off == OFF_CTRL);
    assign w_st_wr   = w_wr & (w_off == OFF_STATUS);
    assign w_data_rd = w_rd & (w_off == OFF_DATA);

    assign w_tx_flush = w_ctrl_wr & i_dout24[CTRL_TX_FLUSH];
    assign w_rx_flush = w_ctrl_wr & i_dout24[CTRL_RX_FLUSH];

    // In loopback the TX queue drains internally and the stream stays idle.
    assign o_txv     = r_ctrl.tx_en & ~r_ctrl.loop & ~w_tx_empty;
    assign o_txd     = w_tx_head;
    assign w_tx_push = w_wr & (w_off == OFF_DATA);
    assign w_tx_pop  = r_ctrl.loop ? (r_ctrl.tx_en & ~w_tx_empty) : (o_txv & i_txr);

    assign w_loop_push = r_ctrl.loop & w_tx_pop & ~w_tx_flush;
    assign o_rxr       = r_ctrl.rx_en & ~r_ctrl.loop & ~w_rx_full;
    assign w_rx_push   = r_ctrl.loop ? w_loop_push : (i_rxv & o_rxr);
    assign w_rx_wdata  = r_ctrl.loop ? w_tx_head : i_rxd;
    assign w_rx_pop    = w_data_rd & ~w_rx_empty;

    assign w_ovf_set = w_tx_push & w_tx_full & ~w_tx_pop & ~w_tx_flush;
    assign w_unf_set = w_data_rd & w_rx_empty;

    dspuva_sync_fifo #(.WIDTH(24), .DEPTH(DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_flush (w_tx_flush),
        .i_data  (i_dout24),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_cnt),
        .o_head  (w_tx_head)
    );

    dspuva_sync_fifo #(.WIDTH(24), .DEPTH(DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_flush (w_rx_flush),
        .i_data  (w_rx_wdata),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_cnt),
        .o_head  (w_rx_head)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ctrl    <= '0;
            r_scratch <= '0;
            r_txovf   <= 1'b0;
            r_rxunf   <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl.tx_en <= i_dout24[CTRL_TX_EN];
                r_ctrl.rx_en <= i_dout24[CTRL_RX_EN];
                r_ctrl.loop  <= i_dout24[CTRL_LOOP];
            end
            if (w_wr && (w_off == OFF_SCRATCH)) r_scratch <= i_dout24;
            // A set in the same cycle as a write-1-to-clear wins.
            if (w_ovf_set)                         r_txovf <= 1'b1;
            else if (w_st_wr && i_dout24[ST_TXOVF]) r_txovf <= 1'b0;
            if (w_unf_set)                         r_rxunf <= 1'b1;
            else if (w_st_wr && i_dout24[ST_RXUNF]) r_rxunf <= 1'b0;
        end
    end

    always_comb begin
        w_status = '0;
        w_status[ST_TXCNT_LSB +: 4] = 4'(w_tx_cnt);
        w_status[ST_RXCNT_LSB +: 4] = 4'(w_rx_cnt);
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_RX_EMPTY] = w_rx_empty;
        w_status[ST_TXOVF]    = r_txovf;
        w_status[ST_RXUNF]    = r_rxunf;
    end

    always_comb begin
        w_rdata = '0;
        if (o_sel) begin
            case (w_off)
                OFF_DATA:   w_rdata = w_rx_head;
                OFF_STATUS: w_rdata = w_status;
                OFF_CTRL: begin
                    w_rdata[CTRL_TX_EN] = r_ctrl.tx_en;
                    w_rdata[CTRL_RX_EN] = r_ctrl.rx_en;
                    w_rdata[CTRL_LOOP]  = r_ctrl.loop;
                end
                default:    w_rdata = r_scratch;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_din <= '0;
        else         r_din <= w_rdata;
    end

    assign o_din = r_din;

endmodule

// File: tb/tb_dspuva_io_port.sv
// Self-checking bench for dspuva_io_port: register table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_dspuva_io_port;

    localparam logic [7:0] BASE  = 8'h10;
    localparam int         DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  port;
    logic        ior, iow;
    logic [23:0] dout;
    logic [23:0] din;
    logic        sel;
    logic [23:0] txd;
    logic        txv;
    logic        txr;
    logic [23:0] rxd;
    logic        rxv;
    logic        rxr;

    int n_checks = 0;
    int n_fail   = 0;

    dspuva_io_port #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_port   (port),
        .i_ior    (ior),
        .i_iow    (iow),
        .i_dout24 (dout),
        .o_din    (din),
        .o_sel    (sel),
        .o_txd    (txd),
        .o_txv    (txv),
        .i_txr    (txr),
        .i_rxd    (rxd),
        .i_rxv    (rxv),
        .o_rxr    (rxr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; ior = 0; iow = 0; port = 8'h00; dout = 0;
        txr = 0; rxv = 0; rxd = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic io_wr(input logic [1:0] off, input logic [23:0] d);
        port = BASE | {6'd0, off}; iow = 1'b1; dout = d;
        @(posedge clk); #1 iow = 1'b0;
    endtask

    task automatic io_rd(input logic [1:0] off, output logic [23:0] v);
        port = BASE | {6'd0, off};
        @(posedge clk); #1 ior = 1'b1; v = din;
        @(posedge clk); #1 ior = 1'b0;
    endtask

    task automatic rx_push(input logic [23:0] w);
        rxv = 1'b1; rxd = w;
        @(posedge clk); #1 rxv = 1'b0;
    endtask

    // Behavioural model: plain queues plus flag/control bits.
    logic [23:0] mtx[$];
    logic [23:0] mrx[$];
    bit          m_txen, m_rxen, m_loop, m_ovf, m_unf;
    logic [23:0] m_scr;

    function automatic bit m_sel(input logic [7:0] p);
        return p[7:2] == 6'(BASE >> 2);
    endfunction

    function automatic logic [23:0] m_read(input logic [7:0] p);
        if (!m_sel(p)) return 24'h0;
        case (p[1:0])
            2'd0:    return (mrx.size() > 0) ? mrx[0] : 24'h0;
            2'd1:    return {12'h0, m_unf, m_ovf, mrx.size() == 0, mtx.size() == DEPTH,
                             4'(mrx.size()), 4'(mtx.size())};
            2'd2:    return {21'h0, m_loop, m_rxen, m_txen};
            default: return m_scr;
        endcase
    endfunction

    task automatic m_step(input logic [7:0] p, input logic r, input logic w,
                          input logic [23:0] d, input logic tr,
                          input logic [23:0] rdat, input logic rv);
        bit          s        = m_sel(p);
        logic [1:0]  o        = p[1:0];
        bit          wr       = w && s;
        bit          rd       = r && s;
        bit          txf      = wr && o == 2 && d[3];
        bit          rxf      = wr && o == 2 && d[4];
        int          ts       = mtx.size();
        int          rs       = mrx.size();
        bit          txv_m    = m_txen && !m_loop && ts > 0;
        bit          txpop    = m_loop ? (m_txen && ts > 0) : (txv_m && tr);
        bit          rxr_m    = m_rxen && !m_loop && rs < DEPTH;
        logic [23:0] lw       = (ts > 0) ? mtx[0] : 24'h0;
        bit          rxpop    = rd && o == 0 && rs > 0;
        bit          unf_set  = rd && o == 0 && rs == 0;
        bit          rxpush   = m_loop ? (txpop && !txf) : (rv && rxr_m);
        logic [23:0] rw       = m_loop ? lw : rdat;
        bit          txpush   = wr && o == 0;
        bit          ovf_set  = txpush && !txf && ts == DEPTH && !txpop;
        if (txf) mtx.delete();
        else begin
            if (txpop) void'(mtx.pop_front());
            if (txpush && (ts < DEPTH || txpop)) mtx.push_back(d);
        end
        if (rxf) mrx.delete();
        else begin
            if (rxpop) void'(mrx.pop_front());
            if (rxpush && (rs < DEPTH || rxpop)) mrx.push_back(rw);
        end
        if (ovf_set) m_ovf = 1;
        else if (wr && o == 1 && d[10]) m_ovf = 0;
        if (unf_set) m_unf = 1;
        else if (wr && o == 1 && d[11]) m_unf = 0;
        if (wr && o == 2) begin
            m_txen = d[0]; m_rxen = d[1]; m_loop = d[2];
        end
        if (wr && o == 3) m_scr = d;
    endtask

    typedef struct {
        logic [1:0]  off;
        logic        is_wr;
        logic [23:0] data;
        logic [23:0] exp;
    } reg_vec_t;

    reg_vec_t    tbl[$];
    logic [23:0] v;
    logic [23:0] words[9];
    logic [23:0] exp_din;

    initial begin
        tbl.push_back('{2'd1, 1'b0, 24'h0,      24'h000200});
        tbl.push_back('{2'd3, 1'b1, 24'h5A5A5A, 24'h0});
        tbl.push_back('{2'd3, 1'b0, 24'h0,      24'h5A5A5A});
        tbl.push_back('{2'd2, 1'b1, 24'h00001F, 24'h0});
        tbl.push_back('{2'd2, 1'b0, 24'h0,      24'h000007});
        tbl.push_back('{2'd2, 1'b1, 24'h000000, 24'h0});
        tbl.push_back('{2'd2, 1'b0, 24'h0,      24'h000000});
        tbl.push_back('{2'd3, 1'b1, 24'hFFFFFF, 24'h0});
        tbl.push_back('{2'd3, 1'b0, 24'h0,      24'hFFFFFF});
        tbl.push_back('{2'd3, 1'b1, 24'h000000, 24'h0});
        tbl.push_back('{2'd3, 1'b0, 24'h0,      24'h000000});

        do_reset();
        chk("reset_din", din, 24'h0);
        chk("reset_txv", {23'h0, txv}, 24'h0);
        chk("reset_rxr", {23'h0, rxr}, 24'h0);
        chk("reset_txd", txd, 24'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_wr) io_wr(tbl[i].off, tbl[i].data);
            else begin
                io_rd(tbl[i].off, v);
                chk($sformatf("table_rd%0d", i), v, tbl[i].exp);
            end
        end

        // TX stream ordering
        io_wr(2'd2, 24'h3);
        io_wr(2'd0, 24'h123456);
        io_wr(2'd0, 24'hABCDEF);
        txr = 1'b1;
        chk("tx1_txv", {23'h0, txv}, 24'h1);
        chk("tx1_txd", txd, 24'h123456);
        @(posedge clk); #1;
        chk("tx2_txv", {23'h0, txv}, 24'h1);
        chk("tx2_txd", txd, 24'hABCDEF);
        @(posedge clk); #1;
        chk("tx_idle_txv", {23'h0, txv}, 24'h0);
        txr = 1'b0;
        io_rd(2'd1, v);
        chk("tx_status_empty", v, 24'h000200);

        // TX overflow and drain
        for (int i = 0; i < 9; i++) begin
            words[i] = 24'h100000 + 24'(i);
            io_wr(2'd0, words[i]);
        end
        io_rd(2'd1, v);
        chk("tx_full_status", v, 24'h000708);
        io_wr(2'd1, 24'h000400);
        io_rd(2'd1, v);
        chk("txovf_clear", v, 24'h000308);
        txr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_txv%0d", i), {23'h0, txv}, 24'h1);
            chk($sformatf("drain_txd%0d", i), txd, words[i]);
            @(posedge clk); #1;
        end
        chk("drain_done_txv", {23'h0, txv}, 24'h0);
        txr = 1'b0;

        // RX path and underflow
        io_wr(2'd2, 24'h2);
        chk("rx_rxr_on", {23'h0, rxr}, 24'h1);
        for (int i = 0; i < 3; i++) rx_push(24'h200000 + 24'(i));
        io_rd(2'd1, v);
        chk("rx3_status", v, 24'h000030);
        for (int i = 0; i < 3; i++) begin
            io_rd(2'd0, v);
            chk($sformatf("rx_in%0d", i), v, 24'h200000 + 24'(i));
        end
        io_rd(2'd0, v);
        chk("rx_underflow_din", v, 24'h0);
        io_rd(2'd1, v);
        chk("rxunf_status", v, 24'h000A00);
        io_wr(2'd1, 24'h000800);

        // RX fill with concurrent pop/push
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("fill_rxr%0d", i), {23'h0, rxr}, 24'h1);
            rx_push(24'h300000 + 24'(i));
        end
        port = BASE;
        @(posedge clk); #1;
        ior = 1'b1; rxv = 1'b1; rxd = 24'h300007;
        chk("both_pop_din", din, 24'h300000);
        chk("both_rxr", {23'h0, rxr}, 24'h1);
        @(posedge clk); #1;
        ior = 1'b0; rxv = 1'b0;
        io_rd(2'd1, v);
        chk("both_count", v, 24'h000070);
        chk("pre_full_rxr", {23'h0, rxr}, 24'h1);
        rx_push(24'h300008);
        chk("full_rxr", {23'h0, rxr}, 24'h0);
        rx_push(24'hBADBAD);
        io_rd(2'd1, v);
        chk("rx_full_status", v, 24'h000080);
        for (int i = 1; i <= 8; i++) begin
            io_rd(2'd0, v);
            chk($sformatf("rx_order%0d", i), v, 24'h300000 + 24'(i));
            chk($sformatf("rx_rxr_after%0d", i), {23'h0, rxr}, 24'h1);
        end

        // Loopback
        io_wr(2'd2, 24'h7);
        for (int i = 0; i < 5; i++) begin
            io_wr(2'd0, 24'h400000 + 24'(i));
            chk($sformatf("loop_txv%0d", i), {23'h0, txv}, 24'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        io_rd(2'd1, v);
        chk("loop_status", v, 24'h000050);
        for (int i = 0; i < 5; i++) begin
            io_rd(2'd0, v);
            chk($sformatf("loop_rd%0d", i), v, 24'h400000 + 24'(i));
        end

        // Outside window
        port = 8'h20;
        @(posedge clk); #1 ior = 1'b1;
        chk("outside_din", din, 24'h0);
        chk("outside_sel", {23'h0, sel}, 24'h0);
        @(posedge clk); #1 ior = 1'b0;
        port = BASE | 8'h3;
        #1 chk("inside_sel", {23'h0, sel}, 24'h1);

        // TX flush
        io_wr(2'd2, 24'h0);
        for (int i = 0; i < 4; i++) io_wr(2'd0, 24'h500000 + 24'(i));
        io_rd(2'd1, v);
        chk("preflush_status", v, 24'h000204);
        io_wr(2'd2, 24'h8);
        io_rd(2'd1, v);
        chk("flush_status", v, 24'h000200);

        // Reset mid-transfer
        for (int i = 0; i < 3; i++) io_wr(2'd0, 24'h600000 + 24'(i));
        io_wr(2'd2, 24'h3);
        do_reset();
        chk("rst_mid_txv", {23'h0, txv}, 24'h0);
        io_rd(2'd1, v);
        chk("rst_mid_status", v, 24'h000200);

        // Randomized run against the queue model
        do_reset();
        mtx.delete(); mrx.delete();
        m_txen = 0; m_rxen = 0; m_loop = 0; m_ovf = 0; m_unf = 0; m_scr = 0;
        @(posedge clk); #1;
        exp_din = 24'h0;
        for (int c = 0; c < 3000; c++) begin
            logic [7:0]  p;
            int          op;
            logic [23:0] d;
            chk("rnd_din", din, exp_din);
            p = BASE | 8'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) p = 8'($urandom_range(0, 255));
            op = $urandom_range(0, 3);
            d  = 24'($urandom);
            if (p[1:0] == 2'd2 && $urandom_range(0, 7) != 0) d[4:3] = 2'b00;
            port = p; ior = (op == 1); iow = (op == 2); dout = d;
            txr  = 1'($urandom_range(0, 1));
            rxv  = 1'($urandom_range(0, 1));
            rxd  = 24'($urandom);
            #1;
            chk("rnd_sel", {23'h0, sel}, {23'h0, m_sel(p)});
            chk("rnd_txv", {23'h0, txv},
                {23'h0, m_txen && !m_loop && mtx.size() > 0});
            chk("rnd_txd", txd, (mtx.size() > 0) ? mtx[0] : 24'h0);
            chk("rnd_rxr", {23'h0, rxr},
                {23'h0, m_rxen && !m_loop && mrx.size() < DEPTH});
            exp_din = m_read(p);
            m_step(p, ior, iow, d, txr, rxd, rxv);
            @(posedge clk); #1;
        end
        ior = 0; iow = 0; rxv = 0; txr = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
